// File: rtl/guess_round_engine.sv
// One player's timed guessing round: latches a target, counts down whole seconds, scores hits.
// Optional time penalty on a wrong guess is enabled by defining GUESS_PENALTY_EN.
module guess_round_engine #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int ROUND_SECS   = 30,
  parameter int PENALTY_SECS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       submit,
  input  logic [7:0] rand_in,
  input  logic [7:0] guess_in,
  output logic [7:0] target,
  output logic [7:0] score,
  output logic [5:0] secs_left,
  output logic       busy,
  output logic       done,
  output logic       hit,
  output logic       miss,
  output logic       timesup
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
`ifdef GUESS_PENALTY_EN
  localparam logic PEN_EN = 1'b1;
`else
  localparam logic PEN_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    target_q, target_d;
  logic [7:0]    score_q, score_d;
  logic [5:0]    secs_q, secs_d;
  logic          hit_q, hit_d;
  logic          miss_q, miss_d;
  logic          timesup_q, timesup_d;
  logic          tick;
  logic          wrong;
  logic [6:0]    loss;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      target_q  <= '0;
      score_q   <= '0;
      secs_q    <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      timesup_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      target_q  <= target_d;
      score_q   <= score_d;
      secs_q    <= secs_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      timesup_q <= timesup_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    target_d  = target_q;
    score_d   = score_q;
    secs_d    = secs_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    timesup_d = 1'b0;
    tick      = 1'b0;
    wrong     = 1'b0;
    loss      = '0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          target_d = rand_in;
          score_d  = '0;
          secs_d   = 6'(ROUND_SECS);
          presc_d  = '0;
        end
      end
      RUN: begin
        tick    = (presc_q == PW'(CLK_HZ - 1));
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (submit) begin
          if (guess_in == target_q) begin
            hit_d    = 1'b1;
            target_d = rand_in;
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
          end else begin
            miss_d = 1'b1;
            wrong  = 1'b1;
          end
        end
        // Seconds lost this cycle: one per tick plus the penalty on a wrong guess.
        loss = {6'd0, tick} + ((PEN_EN && wrong) ? 7'(PENALTY_SECS) : 7'd0);
        if (loss != 7'd0) begin
          if ({1'b0, secs_q} <= loss) begin
            secs_d    = '0;
            state_d   = DONE;
            timesup_d = 1'b1;
          end else begin
            secs_d = secs_q - loss[5:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign target    = target_q;
  assign score     = score_q;
  assign secs_left = secs_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign timesup   = timesup_q;

endmodule

// File: tb/tb_guess_round_engine.sv
// Bench for guess_round_engine: directed table, multi-cycle corner sequences and a
// randomized run checked against a cycle-level model of the round rules.
module tb_guess_round_engine;

  localparam int CLK_HZ = 10;
  localparam int ROUND  = 3;
  localparam int PEN    = 2;
`ifdef GUESS_PENALTY_EN
  localparam int PEN_S = PEN;
`else
  localparam int PEN_S = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, submit = 1'b0;
  logic [7:0] rand_in = 8'h00, guess_in = 8'h00;
  logic [7:0] target, score;
  logic [5:0] secs_left;
  logic       busy, done, hit, miss, timesup;

  logic       s_start = 1'b0, s_submit = 1'b0;
  logic [7:0] s_rand = 8'h00, s_guess = 8'h00;
  logic [7:0] s_target, s_score;
  logic [5:0] s_secs;
  logic       s_busy, s_done, s_hit, s_miss, s_timesup;

  int n_checks = 0;
  int n_errors = 0;

  guess_round_engine #(.CLK_HZ(CLK_HZ), .ROUND_SECS(ROUND), .PENALTY_SECS(PEN)) dut (
    .clk(clk), .rst(rst), .start(start), .submit(submit), .rand_in(rand_in),
    .guess_in(guess_in), .target(target), .score(score), .secs_left(secs_left),
    .busy(busy), .done(done), .hit(hit), .miss(miss), .timesup(timesup));

  // Longer round so 255+ hits fit inside one round.
  guess_round_engine #(.CLK_HZ(100), .ROUND_SECS(ROUND), .PENALTY_SECS(PEN)) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .submit(s_submit), .rand_in(s_rand),
    .guess_in(s_guess), .target(s_target), .score(s_score), .secs_left(s_secs),
    .busy(s_busy), .done(s_done), .hit(s_hit), .miss(s_miss), .timesup(s_timesup));

  always #5 clk = ~clk;

  // Reference model: round state in plain integers.
  bit   m_run, m_done, m_hit, m_miss, m_tu;
  int   m_target, m_score, m_secs, m_cyc;

  task automatic model_update();
    if (!rst) begin
      m_run = 0; m_done = 0; m_hit = 0; m_miss = 0; m_tu = 0;
      m_target = 0; m_score = 0; m_secs = 0; m_cyc = 0;
    end else begin
      int lost;
      m_hit = 0; m_miss = 0; m_tu = 0;
      if (m_run) begin
        m_cyc++;
        lost = ((m_cyc % CLK_HZ) == 0) ? 1 : 0;
        if (submit) begin
          if (int'(guess_in) == m_target) begin
            m_hit = 1;
            m_score = (m_score + 1 > 255) ? 255 : m_score + 1;
            m_target = int'(rand_in);
          end else begin
            m_miss = 1;
            lost += PEN_S;
          end
        end
        if (lost > 0) begin
          if (lost >= m_secs) begin
            m_secs = 0; m_run = 0; m_done = 1; m_tu = 1;
          end else begin
            m_secs -= lost;
          end
        end
      end else if (start) begin
        m_run = 1; m_done = 0; m_target = int'(rand_in);
        m_score = 0; m_secs = ROUND; m_cyc = 0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".target"},  32'(target),    32'(m_target));
    chk({tag, ".score"},   32'(score),     32'(m_score));
    chk({tag, ".secs"},    32'(secs_left), 32'(m_secs));
    chk({tag, ".busy"},    32'(busy),      32'(m_run));
    chk({tag, ".done"},    32'(done),      32'(m_done));
    chk({tag, ".hit"},     32'(hit),       32'(m_hit));
    chk({tag, ".miss"},    32'(miss),      32'(m_miss));
    chk({tag, ".timesup"}, 32'(timesup),   32'(m_tu));
  endtask

  task automatic drive(input logic st, input logic sb, input logic [7:0] r, input logic [7:0] g);
    start = st; submit = sb; rand_in = r; guess_in = g;
  endtask

  task automatic do_reset();
    rst = 1'b0; drive(0, 0, 8'h00, 8'h00);
    cyc();
    rst = 1'b1;
  endtask

  typedef struct {
    logic       rst, start, submit;
    logic [7:0] rnd, gs;
    logic [7:0] e_target, e_score;
    logic [5:0] e_secs;
    logic       e_busy, e_done, e_hit, e_miss, e_tu;
  } vec_t;

  vec_t vt[7];

  initial begin
    int k;
    vt[0] = '{0, 0, 0, 8'h00, 8'h00, 8'h00, 8'd0, 6'd0, 0, 0, 0, 0, 0};
    vt[1] = '{0, 1, 1, 8'h5A, 8'h11, 8'h00, 8'd0, 6'd0, 0, 0, 0, 0, 0};
    vt[2] = '{1, 0, 1, 8'h5A, 8'h00, 8'h00, 8'd0, 6'd0, 0, 0, 0, 0, 0};
    vt[3] = '{1, 1, 0, 8'hA5, 8'h00, 8'hA5, 8'd0, 6'd3, 1, 0, 0, 0, 0};
    vt[4] = '{1, 0, 1, 8'h3C, 8'hA5, 8'h3C, 8'd1, 6'd3, 1, 0, 1, 0, 0};
    vt[5] = '{1, 0, 1, 8'h99, 8'h00, 8'h3C, 8'd1, 6'(3 - PEN_S), 1, 0, 0, 1, 0};
    vt[6] = '{1, 1, 0, 8'h77, 8'h00, 8'h3C, 8'd1, 6'(3 - PEN_S), 1, 0, 0, 0, 0};

    // Reset, ignored submit in IDLE, start, hit, miss, start ignored in RUN.
    for (int i = 0; i < 7; i++) begin
      rst = vt[i].rst;
      drive(vt[i].start, vt[i].submit, vt[i].rnd, vt[i].gs);
      cyc();
      chk($sformatf("vec%0d.target", i),  32'(target),    32'(vt[i].e_target));
      chk($sformatf("vec%0d.score", i),   32'(score),     32'(vt[i].e_score));
      chk($sformatf("vec%0d.secs", i),    32'(secs_left), 32'(vt[i].e_secs));
      chk($sformatf("vec%0d.flags", i),   32'({busy, done, hit, miss, timesup}),
          32'({vt[i].e_busy, vt[i].e_done, vt[i].e_hit, vt[i].e_miss, vt[i].e_tu}));
    end

    // Round expiry: timesup exactly 30 cycles after the start edge.
    do_reset();
    drive(1, 0, 8'hA5, 8'h00); cyc();
    chk("t2.start_busy", 32'({busy, secs_left}), 32'({1'b1, 6'd3}));
    drive(0, 0, 8'h00, 8'h00);
    for (k = 1; k <= 40; k++) begin
      cyc();
      cmp_model("t2");
      if (timesup) break;
    end
    chk("t2.latency", 32'(k), 32'd30);
    cyc();
    chk("t2.after", 32'({busy, done, timesup, secs_left}), 32'({1'b0, 1'b1, 1'b0, 6'd0}));

    // Correct guess on the final tick cycle, then restart from DONE.
    drive(1, 0, 8'hC3, 8'h00); cyc(); cmp_model("t5s");
    drive(0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 29; i++) begin cyc(); end
    drive(0, 1, 8'h44, 8'hC3); cyc(); cmp_model("t5t");
    chk("t5.final", 32'({hit, timesup, done, score}), 32'({1'b1, 1'b1, 1'b1, 8'd1}));
    drive(0, 1, 8'h00, 8'h44); cyc();
    chk("t5.done_submit", 32'({hit, miss, score, target}), 32'({1'b0, 1'b0, 8'd1, 8'h44}));
    drive(1, 0, 8'h12, 8'h00); cyc();
    chk("t5.restart", 32'({busy, score, secs_left, target}), 32'({1'b1, 8'd0, 6'd3, 8'h12}));

    // Wrong guesses: penalty build drains the clock, default build leaves it alone.
    drive(0, 1, 8'h00, 8'h99); cyc(); cmp_model("t6a");
`ifdef GUESS_PENALTY_EN
    chk("t6.first", 32'({miss, secs_left}), 32'({1'b1, 6'd1}));
    cyc(); cmp_model("t6b");
    chk("t6.second", 32'({miss, timesup, done, secs_left}), 32'({1'b1, 1'b1, 1'b1, 6'd0}));
`else
    chk("t6.nopen", 32'({miss, timesup, secs_left}), 32'({1'b1, 1'b0, 6'd3}));
`endif

    // Mid-round reset with score 2.
    do_reset();
    drive(1, 0, 8'h21, 8'h00); cyc();
    drive(0, 1, 8'h22, 8'h21); cyc();
    drive(0, 1, 8'h23, 8'h22); cyc();
    chk("t7.score2", 32'(score), 32'd2);
    rst = 1'b0; drive(0, 1, 8'h00, 8'h23); cyc();
    chk("t7.rst", 32'({target, score, secs_left, busy, done, hit, miss, timesup}), 32'd0);
    rst = 1'b1; drive(0, 0, 8'h00, 8'h00);

    // Score saturation on the long-round instance.
    s_start = 1; s_rand = 8'h5A; cyc();
    s_start = 0; s_submit = 1; s_guess = 8'h5A;
    for (int i = 1; i <= 256; i++) begin
      cyc();
      if (i == 1)   chk("t4.first", 32'({s_hit, s_score}), 32'({1'b1, 8'd1}));
      if (i == 255) chk("t4.reach", 32'(s_score), 32'd255);
      if (i == 256) chk("t4.sat", 32'({s_hit, s_busy, s_score}), 32'({1'b1, 1'b1, 8'd255}));
    end
    s_submit = 0;

    // Randomized run against the model.
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 299) != 0);
      start = ($urandom_range(0, 15) == 0);
      submit = ($urandom_range(0, 2) == 0);
      rand_in = 8'($urandom);
      guess_in = ($urandom_range(0, 1) == 1) ? 8'(m_target) : 8'($urandom);
      cyc();
      cmp_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
